// File: rtl/multdiv_if.sv
// Start/operand/result signal bundle between the decoder/hazard logic and the multiply/divide engine.
interface multdiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) engine, one iteration per cycle,
// with overflow and divide-by-zero reporting alongside a one-cycle result-ready pulse.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_mult;
  logic             w_start_div;
  logic             w_ld_mul;
  logic             w_ld_div;
  logic             w_ld_dz;

  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_dz;
  logic             r_div_ovf;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_prod_s;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_ovf;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_div_res;

  // Operand magnitudes; MIN_INT maps to 2^(WIDTH-1), which is still exact as unsigned.
  assign w_abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
  assign w_abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : PW'(0));
  assign w_prod_s  = r_neg ? (~w_acc_nxt + PW'(1)) : w_acc_nxt;
  assign w_mul_res = w_prod_s[WIDTH-1:0];
  assign w_mul_ovf = !((&w_prod_s[PW-1:WIDTH-1]) || !(|w_prod_s[PW-1:WIDTH-1]));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dvsr};
  assign w_div_ge    = ~w_div_diff[WIDTH];
  assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_div_ge};
  assign w_rem_nxt   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_res   = r_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_start_mult = 1'b0;
    w_start_div  = 1'b0;
    w_ld_mul     = 1'b0;
    w_ld_div     = 1'b0;
    w_ld_dz      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_mult && !bus.ctrl_div) begin
          w_start_mult = 1'b1;
          w_state_nxt  = S_MULT;
        end else if (bus.ctrl_div && !bus.ctrl_mult) begin
          w_start_div = 1'b1;
          w_state_nxt = S_DIV;
        end
      end
      S_MULT: begin
        if (r_cnt == LAST) begin
          w_ld_mul    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        if (r_dz) begin
          w_ld_dz     = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == LAST) begin
          w_ld_div    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath and registered outputs; result/exception are loaded on the edge entering DONE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_div_ovf <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_rdy  <= (w_state_nxt == S_DONE);

      if (w_start_mult || w_start_div) begin
        r_cnt     <= '0;
        r_neg     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_mcand   <= PW'(w_abs_a);
        r_mplier  <= w_abs_b;
        r_acc     <= '0;
        r_quo     <= w_abs_a;
        r_dvsr    <= w_abs_b;
        r_rem     <= '0;
        r_dz      <= w_start_div && (bus.data_operandB == '0);
        r_div_ovf <= w_start_div && (bus.data_operandA == MIN_INT) && (&bus.data_operandB);
      end else if (r_state == S_MULT) begin
        r_cnt    <= r_cnt + CW'(1);
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else if (r_state == S_DIV) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end

      if (w_ld_mul) begin
        r_result <= w_mul_res;
        r_exc    <= w_mul_ovf;
      end else if (w_ld_div) begin
        r_result <= w_div_res;
        r_exc    <= r_div_ovf;
      end else if (w_ld_dz) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit: latency, results, exceptions, strobe filtering and reset abort.
module tb_multdiv_unit;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start one operation, scramble operands afterwards, optionally inject a stray ctrl_div
  // mid-flight and/or a ctrl_mult in the DONE cycle, then check latency, result and hold.
  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_exc, input int exp_lat,
                        input int inject_cyc, input bit strobe_at_done);
    int cyc;
    bit busy_ok;
    int extra_rdy;
    bus.ctrl_mult     = !is_div;
    bus.ctrl_div      = is_div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    tick();
    cyc = 1;
    bus.ctrl_mult     = 1'b0;
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'h0000_0003;
    busy_ok = 1'b1;
    while (!bus.data_resultRDY && cyc < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (cyc == inject_cyc) bus.ctrl_div = 1'b1;
      tick();
      bus.ctrl_div = 1'b0;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, bus.data_result, exp_res);
    check({tag, "_exc"}, 32'(bus.data_exception), 32'(exp_exc));
    check({tag, "_busy_run"}, 32'(busy_ok && bus.busy), 32'd1);
    if (strobe_at_done) bus.ctrl_mult = 1'b1;
    tick();
    bus.ctrl_mult = 1'b0;
    check({tag, "_rdy_drop"}, 32'(bus.data_resultRDY), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    extra_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.data_resultRDY || bus.busy) extra_rdy++;
    end
    check({tag, "_quiet"}, 32'(extra_rdy), 32'd0);
    check({tag, "_hold"}, bus.data_result, exp_res);
  endtask

  initial begin
    int rdy_seen;
    n_checks = 0;
    n_errors = 0;
    reset_n           = 1'b0;
    bus.ctrl_mult     = 1'b1;
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = 32'd6;
    bus.data_operandB = 32'd7;
    tick();
    tick();
    check("rst_busy_in", 32'(bus.busy), 32'd0);
    bus.ctrl_mult = 1'b0;
    reset_n       = 1'b1;
    tick();
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exc", 32'(bus.data_exception), 32'd0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    run_op("mul_6x7",     1'b0, 32'd6,        32'd7,        32'd42,        1'b0, 33, -1, 1'b0);
    run_op("mul_m5x3",    1'b0, -32'sd5,      32'd3,        32'hFFFF_FFF1, 1'b0, 33, -1, 1'b0);
    run_op("mul_big",     1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0,        1'b1, 33, -1, 1'b0);
    run_op("mul_min_m1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, -1, 1'b0);
    run_op("mul_min_1",   1'b0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, 33, -1, 1'b0);
    run_op("mul_m1_m1",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        1'b0, 33, -1, 1'b0);
    run_op("mul_max_2",   1'b0, 32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1, 33, -1, 1'b0);
    run_op("div_100_m7",  1'b1, 32'd100,      -32'sd7,      32'hFFFF_FFF2, 1'b0, 33, -1, 1'b0);
    run_op("div_m7_2",    1'b1, -32'sd7,      32'd2,        32'hFFFF_FFFD, 1'b0, 33, -1, 1'b0);
    run_op("div_7_7",     1'b1, 32'd7,        32'd7,        32'd1,         1'b0, 33, -1, 1'b0);
    run_op("div_5_0",     1'b1, 32'd5,        32'd0,        32'd0,         1'b1, 2,  -1, 1'b0);
    run_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, -1, 1'b0);
    run_op("mul_ignore",  1'b0, 32'd4,        32'd5,        32'd20,        1'b0, 33, 10, 1'b1);

    // Both strobes together must not start anything.
    bus.ctrl_mult = 1'b1;
    bus.ctrl_div  = 1'b1;
    tick();
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    check("both_strobes_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a divide aborts it without a ready pulse.
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd7;
    tick();
    bus.ctrl_div = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset_n = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("abort_result", bus.data_result, 32'd0);
    reset_n  = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.data_resultRDY || bus.busy) rdy_seen++;
    end
    check("abort_no_rdy", 32'(rdy_seen), 32'd0);
    run_op("mul_3x3", 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, 33, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
